// File: rtl/cpu_mc.sv
// cpu_mc -- multi-cycle accumulator-free CPU core.
//
// Fetches PROG_LEN instructions starting at pc=0, and for each one reads one
// or two operands from an external data memory. It then computes the result
// and issues a single write strobe. After the last instruction the core parks
// in HALT until start is seen again.
//
// Instruction word (INST_WIDTH = 2 + 3*ADDRESS_WIDTH):
//   [1:0]   opcode  00 ADD, 01 NOT (A only), 10 SUB, 11 AND
//   A       next ADDRESS_WIDTH bits
//   B       next ADDRESS_WIDTH bits
//   Res     top ADDRESS_WIDTH bits
//
// Ports:
//   clk, rstn             clock, async active-low reset
//   start                 run request (sampled only in IDLE / HALT)
//   inst                  instruction word, valid the cycle after start_fetch
//   pc, start_fetch       instruction address / read strobe
//   addr_opA/opB/Res      data addresses
//   readA, readB          operand read strobes (data returns next cycle)
//   data_opA, data_opB    operand read data
//   data_Res, write_Res   result data / one-cycle write strobe
//   zero_flag, carry_flag ALU flags, only present with CPU_MC_FLAGS_EN
//   busy, done            running / halted status
//
// Optional feature macro: CPU_MC_FLAGS_EN adds the zero/carry flag outputs.
//
// All outputs come straight from flops. Each strobe flop is loaded from the
// next state, so a strobe is high exactly while the FSM sits in its state.

module cpu_mc #(
    parameter int DATA_WIDTH    = 10,
    parameter int ADDRESS_WIDTH = 3,
    parameter int PROG_LEN      = 8,
    localparam int INST_WIDTH   = 2 + 3*ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic [INST_WIDTH-1:0]    inst,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic                     start_fetch,
    output logic [ADDRESS_WIDTH-1:0] addr_opA,
    output logic [ADDRESS_WIDTH-1:0] addr_opB,
    output logic [ADDRESS_WIDTH-1:0] addr_Res,
    output logic                     readA,
    output logic                     readB,
    input  logic [DATA_WIDTH-1:0]    data_opA,
    input  logic [DATA_WIDTH-1:0]    data_opB,
    output logic [DATA_WIDTH-1:0]    data_Res,
    output logic                     write_Res,
`ifdef CPU_MC_FLAGS_EN
    output logic                     zero_flag,
    output logic                     carry_flag,
`endif
    output logic                     busy,
    output logic                     done
);

    localparam int AW = ADDRESS_WIDTH;
    localparam logic [AW-1:0] LAST_PC = AW'(PROG_LEN - 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_NOT = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_READ_A, S_READ_B, S_EXEC, S_WRITE, S_HALT
    } state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           pc_q, pc_d;
    logic [1:0]              op_q, op_d;
    logic [AW-1:0]           addr_a_q, addr_a_d;
    logic [AW-1:0]           addr_b_q, addr_b_d;
    logic [AW-1:0]           addr_r_q, addr_r_d;
    logic [DATA_WIDTH-1:0]   opa_q, opa_d;
    logic [DATA_WIDTH-1:0]   res_q, res_d;
    logic                    fetch_q, fetch_d;
    logic                    rda_q, rda_d;
    logic                    rdb_q, rdb_d;
    logic                    wr_q, wr_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    // For NOT the single operand arrives during EXEC itself, so it is taken
    // straight from the read port instead of the capture register.
    logic [DATA_WIDTH-1:0]   alu_a;
    logic [DATA_WIDTH-1:0]   alu_res;

    assign alu_a = (op_q == OP_NOT) ? data_opA : opa_q;

`ifdef CPU_MC_FLAGS_EN
    logic alu_cy;
    logic zero_q, zero_d;
    logic carry_q, carry_d;

    // The extra top bit is the carry of ADD and the borrow of SUB; for NOT
    // and AND it is forced to 0.
    always_comb begin
        {alu_cy, alu_res} = '0;
        case (op_q)
            OP_ADD:  {alu_cy, alu_res} = {1'b0, alu_a} + {1'b0, data_opB};
            OP_SUB:  {alu_cy, alu_res} = {1'b0, alu_a} - {1'b0, data_opB};
            OP_NOT:  {alu_cy, alu_res} = {1'b0, ~alu_a};
            default: {alu_cy, alu_res} = {1'b0, alu_a & data_opB};
        endcase
    end
`else
    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_ADD:  alu_res = alu_a + data_opB;
            OP_SUB:  alu_res = alu_a - data_opB;
            OP_NOT:  alu_res = ~alu_a;
            default: alu_res = alu_a & data_opB;
        endcase
    end
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        op_d     = op_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        addr_r_d = addr_r_q;
        opa_d    = opa_q;
        res_d    = res_q;
`ifdef CPU_MC_FLAGS_EN
        zero_d   = zero_q;
        carry_d  = carry_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                op_d     = inst[1:0];
                addr_a_d = inst[AW+1:2];
                addr_b_d = inst[2*AW+1:AW+2];
                addr_r_d = inst[3*AW+1:2*AW+2];
                state_d  = S_READ_A;
            end
            S_READ_A: state_d = (op_q == OP_NOT) ? S_EXEC : S_READ_B;
            S_READ_B: begin
                opa_d   = data_opA;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                res_d   = alu_res;
`ifdef CPU_MC_FLAGS_EN
                zero_d  = (alu_res == '0);
                carry_d = alu_cy;
`endif
                state_d = S_WRITE;
            end
            S_WRITE: begin
                // Stop on the last pc rather than comparing after the
                // increment, so a full-size program never wraps pc.
                if (pc_q == LAST_PC) begin
                    state_d = S_HALT;
                end else begin
                    pc_d    = pc_q + AW'(1);
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        fetch_d = (state_d == S_FETCH);
        rda_d   = (state_d == S_READ_A);
        rdb_d   = (state_d == S_READ_B);
        wr_d    = (state_d == S_WRITE);
        busy_d  = (state_d != S_IDLE) && (state_d != S_HALT);
        done_d  = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            op_q     <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            addr_r_q <= '0;
            opa_q    <= '0;
            res_q    <= '0;
            fetch_q  <= 1'b0;
            rda_q    <= 1'b0;
            rdb_q    <= 1'b0;
            wr_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef CPU_MC_FLAGS_EN
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            op_q     <= op_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            addr_r_q <= addr_r_d;
            opa_q    <= opa_d;
            res_q    <= res_d;
            fetch_q  <= fetch_d;
            rda_q    <= rda_d;
            rdb_q    <= rdb_d;
            wr_q     <= wr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef CPU_MC_FLAGS_EN
            zero_q   <= zero_d;
            carry_q  <= carry_d;
`endif
        end
    end

    assign pc          = pc_q;
    assign start_fetch = fetch_q;
    assign addr_opA    = addr_a_q;
    assign addr_opB    = addr_b_q;
    assign addr_Res    = addr_r_q;
    assign readA       = rda_q;
    assign readB       = rdb_q;
    assign data_Res    = res_q;
    assign write_Res   = wr_q;
    assign busy        = busy_q;
    assign done        = done_q;
`ifdef CPU_MC_FLAGS_EN
    assign zero_flag   = zero_q;
    assign carry_flag  = carry_q;
`endif

endmodule

// File: tb/tb_cpu_mc.sv
// tb_cpu_mc -- self-checking bench for cpu_mc (DATA_WIDTH=10,
// ADDRESS_WIDTH=3, PROG_LEN=3). A behavioural memory answers the
// instruction and operand reads. Each program run is replayed on a plain
// array model, and the bench compares the write pulses it sees against the
// model: address, data, latency, pc order, readB usage and, when built with
// CPU_MC_FLAGS_EN, the flags.

module tb_cpu_mc;
    localparam int DW  = 10;
    localparam int AW  = 3;
    localparam int PL  = 3;
    localparam int IW  = 2 + 3*AW;
    localparam int MOD = 1 << DW;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          start = 1'b0;
    logic [IW-1:0] inst = '0;
    logic [AW-1:0] pc;
    logic          start_fetch;
    logic [AW-1:0] addr_opA, addr_opB, addr_Res;
    logic          readA, readB;
    logic [DW-1:0] data_opA = '0, data_opB = '0;
    logic [DW-1:0] data_Res;
    logic          write_Res;
    logic          busy, done;
`ifdef CPU_MC_FLAGS_EN
    logic          zero_flag, carry_flag;
`endif

    cpu_mc #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .PROG_LEN(PL)) dut (
        .clk(clk), .rstn(rstn), .start(start), .inst(inst), .pc(pc),
        .start_fetch(start_fetch), .addr_opA(addr_opA), .addr_opB(addr_opB),
        .addr_Res(addr_Res), .readA(readA), .readB(readB),
        .data_opA(data_opA), .data_opB(data_opB), .data_Res(data_Res),
        .write_Res(write_Res),
`ifdef CPU_MC_FLAGS_EN
        .zero_flag(zero_flag), .carry_flag(carry_flag),
`endif
        .busy(busy), .done(done));

    always #5 clk = ~clk;

    typedef struct {
        int addr; int data; int lat; int fpc; int rb; int z; int c;
    } wr_t;

    logic [IW-1:0] prog [8];
    logic [DW-1:0] mem  [8];
    wr_t           wq[$];
    int            ncomp = 0, nfail = 0;
    int            cyc = 0, excl_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk(input int op, input int a, input int b, input int r);
        logic [AW-1:0] ra, rb, rr;
        logic [1:0]    ro;
        ra = AW'(a); rb = AW'(b); rr = AW'(r); ro = 2'(op);
        return {rr, rb, ra, ro};
    endfunction

    // Memory: answers a strobe seen in one cycle with data in the next cycle,
    // and drives random junk otherwise so a mistimed capture shows up.
    initial forever begin
        logic          sf, ra, rb;
        logic [AW-1:0] p, aa, ab;
        @(negedge clk);
        sf = start_fetch; ra = readA; rb = readB;
        p = pc; aa = addr_opA; ab = addr_opB;
        if (write_Res) mem[addr_Res] = data_Res;
        @(posedge clk);
        #1;
        inst     = sf ? prog[p]  : IW'($urandom);
        data_opA = ra ? mem[aa]  : DW'($urandom);
        data_opB = rb ? mem[ab]  : DW'($urandom);
    end

    // Monitor: records each write pulse with its timing relative to fetch.
    initial forever begin
        int  fcyc, fpc, rbc;
        wr_t w;
        @(negedge clk);
        cyc++;
        if (int'(start_fetch) + int'(readA) + int'(readB) + int'(write_Res) > 1)
            excl_err++;
        if (start_fetch) begin fcyc = cyc; fpc = int'(pc); rbc = 0; end
        if (readB) rbc++;
        if (write_Res) begin
            w.addr = int'(addr_Res); w.data = int'(data_Res);
            w.lat = cyc - fcyc; w.fpc = fpc; w.rb = rbc;
`ifdef CPU_MC_FLAGS_EN
            w.z = int'(zero_flag); w.c = int'(carry_flag);
`else
            w.z = 0; w.c = 0;
`endif
            wq.push_back(w);
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_pc"},    int'(pc), 0);
        chk({tag, "_sf"},    int'(start_fetch), 0);
        chk({tag, "_rda"},   int'(readA), 0);
        chk({tag, "_rdb"},   int'(readB), 0);
        chk({tag, "_wr"},    int'(write_Res), 0);
        chk({tag, "_addrs"}, int'(addr_opA) + int'(addr_opB) + int'(addr_Res), 0);
        chk({tag, "_data"},  int'(data_Res), 0);
        chk({tag, "_busy"},  int'(busy), 0);
        chk({tag, "_done"},  int'(done), 0);
    endtask

    // Runs the program in prog[] against the current mem[] and checks every
    // write pulse against a sequential replay of the program.
    task automatic run_prog(input string tag, input bit hold);
        int e_addr[PL], e_data[PL], e_lat[PL], e_rb[PL], e_z[PL], e_c[PL];
        int mm[8];
        bit got_done = 0;
        for (int i = 0; i < 8; i++) mm[i] = int'(mem[i]);
        for (int i = 0; i < PL; i++) begin
            int op, a, b, r, av, bv, res, cy;
            op = int'(prog[i][1:0]);  a = int'(prog[i][4:2]);
            b  = int'(prog[i][7:5]);  r = int'(prog[i][10:8]);
            av = mm[a]; bv = mm[b]; cy = 0;
            case (op)
                0: begin res = (av + bv) % MOD; cy = (av + bv >= MOD) ? 1 : 0; end
                1: res = MOD - 1 - av;
                2: begin res = (av - bv + MOD) % MOD; cy = (av < bv) ? 1 : 0; end
                default: res = av & bv;
            endcase
            mm[r] = res;
            e_addr[i] = r; e_data[i] = res; e_z[i] = (res == 0) ? 1 : 0; e_c[i] = cy;
            e_lat[i] = (op == 1) ? 4 : 5;   // FETCH..WRITE inclusive = 5 / 6 cycles
            e_rb[i]  = (op == 1) ? 0 : 1;
        end
        wq.delete();
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int c = 0; c < 200 && !got_done; c++) begin
            @(negedge clk);
            if (done) begin got_done = 1; start = 1'b0; end
        end
        start = 1'b0;
        chk({tag, "_done_reached"}, int'(got_done), 1);
        chk({tag, "_nwrites"}, wq.size(), PL);
        for (int i = 0; i < PL && i < wq.size(); i++) begin
            chk($sformatf("%s_w%0d_addr", tag, i), wq[i].addr, e_addr[i]);
            chk($sformatf("%s_w%0d_data", tag, i), wq[i].data, e_data[i]);
            chk($sformatf("%s_w%0d_lat",  tag, i), wq[i].lat,  e_lat[i]);
            chk($sformatf("%s_w%0d_pc",   tag, i), wq[i].fpc,  i);
            chk($sformatf("%s_w%0d_rdb",  tag, i), wq[i].rb,   e_rb[i]);
`ifdef CPU_MC_FLAGS_EN
            chk($sformatf("%s_w%0d_zf", tag, i), wq[i].z, e_z[i]);
            chk($sformatf("%s_w%0d_cf", tag, i), wq[i].c, e_c[i]);
`endif
        end
        chk({tag, "_halt_pc"},   int'(pc), PL - 1);
        chk({tag, "_halt_busy"}, int'(busy), 0);
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 8; i++) begin
            mem[i]  = DW'($urandom);
            prog[i] = '0;
        end

        // Reset asserted with no clock edge needed.
        #1 rstn = 1'b0;
        #1 chk_zero("reset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);
        chk("idle_sf",   int'(start_fetch), 0);

        // ADD 5+7, NOT 0x00F, ADD 0x3FF+1 overflow.
        mem[1] = 10'd5; mem[2] = 10'd7; mem[4] = 10'h00F;
        mem[6] = 10'h3FF; mem[7] = 10'h001;
        prog[0] = mk(0, 1, 2, 3);
        prog[1] = mk(1, 4, 0, 5);
        prog[2] = mk(0, 6, 7, 0);
        run_prog("dir1", 1'b0);
        if (wq.size() == PL) begin
            chk("add_5_7",   wq[0].data, 12);
            chk("not_00f",   wq[1].data, 'h3F0);
            chk("add_ovf",   wq[2].data, 0);
        end

        // Re-run from HALT with start held: SUB 3-5, AND, SUB 5-3.
        mem[1] = 10'd3; mem[2] = 10'd5; mem[4] = 10'h0F0;
        prog[0] = mk(2, 1, 2, 3);
        prog[1] = mk(3, 3, 4, 5);
        prog[2] = mk(2, 2, 1, 6);
        run_prog("dir2", 1'b1);
        if (wq.size() == PL) chk("sub_3_5", wq[0].data, 'h3FE);

        // Random programs and data, alternating pulsed and held start.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) mem[i] = DW'($urandom);
            for (int i = 0; i < PL; i++) prog[i] = IW'($urandom);
            run_prog($sformatf("rnd%0d", r), r[0]);
        end

        // Drop reset while READ_B is active.
        prog[0] = mk(0, 1, 2, 3);
        wq.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (readB) seen = 1;
        end
        chk("mid_readb_seen", int'(seen), 1);
        #2 rstn = 1'b0;
        #1 chk_zero("midrst");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst_nowrite", wq.size(), 0);
        chk("midrst_idle_busy", int'(busy), 0);
        chk("midrst_idle_done", int'(done), 0);
        run_prog("after_rst", 1'b0);

        chk("strobe_excl", excl_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
